ibex_mem_responder: RTL and testbench

IBEX_MEM_RESPONDER -- requirements
Module: ibex_mem_responder

---
 rtl/ibex_mem_responder.sv | 92 +++++++++
 tb/tb_ibex_mem_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_mem_responder.sv
// Ibex-style data-memory responder: fixed-latency, in-order responses from
// internal word storage with byte-enable writes and out-of-range bus errors.
module ibex_mem_responder #(
    parameter int MemWords       = 1024,
    parameter int RespLatency    = 2,
    parameter int MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        stall_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int AW = $clog2(MemWords);

    logic [31:0]            mem [MemWords];
    logic [2:0]             outstanding;
    logic [RespLatency-1:0] pipe_valid;
    logic [RespLatency-1:0] pipe_err;
    logic [31:0]            pipe_data [RespLatency];

    logic [AW-1:0] word_idx;
    logic          in_range;
    logic          mem_we;
    logic [31:0]   rd_word;
    logic          unused_addr_lsb;

    assign word_idx        = addr_i[AW+1:2];
    assign in_range        = (addr_i[31:AW+2] == '0);
    // Byte offset within the word is don't-care.
    assign unused_addr_lsb = ^addr_i[1:0];

    assign rvalid_o = pipe_valid[RespLatency-1];
    assign gnt_o    = req_i & ~stall_i
                    & ((outstanding < 3'(MaxOutstanding)) | rvalid_o);

    // Reads of writes and of out-of-range words carry zero down the pipe.
    assign rd_word = (in_range & ~we_i) ? mem[word_idx] : '0;
    assign mem_we  = gnt_o & we_i & in_range & rst_ni;

    assign rdata_o = rvalid_o ? pipe_data[RespLatency-1] : '0;
    assign err_o   = rvalid_o & pipe_err[RespLatency-1];

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_valid <= '0;
            pipe_err   <= '0;
            for (int i = 0; i < RespLatency; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= gnt_o;
            pipe_err[0]   <= gnt_o & ~in_range;
            pipe_data[0]  <= rd_word;
            for (int i = 1; i < RespLatency; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    // Grant and response in the same cycle leave the count unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding <= '0;
        end else if (gnt_o && !rvalid_o) begin
            outstanding <= outstanding + 3'd1;
        end else if (!gnt_o && rvalid_o) begin
            outstanding <= outstanding - 3'd1;
        end
    end

endmodule

// File: tb/tb_ibex_mem_responder.sv
// Bench for ibex_mem_responder: directed vector table, random traffic against
// a queue-based response model, and a reset-with-traffic-in-flight sequence.
module tb_ibex_mem_responder;

    localparam int LAT   = 2;
    localparam int MAXO  = 2;
    localparam int WORDS = 1024;

    logic        clk_i   = 1'b0;
    logic        rst_ni  = 1'b0;
    logic        req_i   = 1'b0;
    logic        we_i    = 1'b0;
    logic [3:0]  be_i    = 4'h0;
    logic [31:0] addr_i  = 32'h0;
    logic [31:0] wdata_i = 32'h0;
    logic        stall_i = 1'b0;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    always #5 clk_i = ~clk_i;

    ibex_mem_responder #(
        .MemWords(WORDS),
        .RespLatency(LAT),
        .MaxOutstanding(MAXO)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .req_i(req_i),
        .gnt_o(gnt_o),
        .we_i(we_i),
        .be_i(be_i),
        .addr_i(addr_i),
        .wdata_i(wdata_i),
        .stall_i(stall_i),
        .rvalid_o(rvalid_o),
        .rdata_o(rdata_o),
        .err_o(err_o)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } resp_t;

    typedef struct {
        logic        r;
        logic        w;
        logic [3:0]  b;
        logic [31:0] a;
        logic [31:0] d;
        logic        s;
        logic        eg;
        logic        ev;
        logic [31:0] ed;
        logic        ee;
    } vec_t;

    resp_t       q[$];
    vec_t        tbl[$];
    logic [31:0] mm [WORDS];
    int          cyc   = 0;
    int          total = 0;
    int          bad   = 0;
    logic        s_gnt, s_rv, s_err;
    logic [31:0] s_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One bus cycle: drive, sample mid-cycle, compare with the model, advance.
    task automatic cycle(input logic r, input logic w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] d, input logic s);
        logic  exp_rv;
        logic  exp_gnt;
        resp_t e;
        int    idx;
        req_i = r; we_i = w; be_i = b; addr_i = a; wdata_i = d; stall_i = s;
        @(negedge clk_i);
        s_gnt = gnt_o; s_rv = rvalid_o; s_rdata = rdata_o; s_err = err_o;
        exp_rv  = (q.size() > 0) && (q[0].due == cyc);
        exp_gnt = r && !s && ((q.size() < MAXO) || exp_rv);
        chk("gnt",    32'(gnt_o),    32'(exp_gnt));
        chk("rvalid", 32'(rvalid_o), 32'(exp_rv));
        chk("rdata",  rdata_o,       exp_rv ? q[0].data : 32'h0);
        chk("err",    32'(err_o),    exp_rv ? 32'(q[0].err) : 32'h0);
        if (exp_rv) void'(q.pop_front());
        if (exp_gnt) begin
            idx    = int'(a >> 2);
            e.due  = cyc + LAT;
            e.err  = (idx >= WORDS);
            e.data = 32'h0;
            if (!e.err) begin
                if (w) begin
                    for (int k = 0; k < 4; k++)
                        if (b[k]) mm[idx][8*k +: 8] = d[8*k +: 8];
                end else begin
                    e.data = mm[idx];
                end
            end
            q.push_back(e);
        end
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    function automatic void add(input logic r, input logic w, input logic [3:0] b,
                                input logic [31:0] a, input logic [31:0] d, input logic s,
                                input logic eg, input logic ev, input logic [31:0] ed,
                                input logic ee);
        vec_t v;
        v.r = r; v.w = w; v.b = b; v.a = a; v.d = d; v.s = s;
        v.eg = eg; v.ev = ev; v.ed = ed; v.ee = ee;
        tbl.push_back(v);
    endfunction

    initial begin
        logic        r, w, s;
        logic [3:0]  b;
        logic [31:0] a, d;

        // Directed vectors: r w be addr wdata stall | gnt rvalid rdata err
        add(1,1,4'hF,32'h40,  32'hDEADBEEF,0, 1,0,32'h0,0);
        add(0,0,4'h0,32'h0,   32'h0,       0, 0,0,32'h0,0);
        add(1,0,4'hF,32'h40,  32'h0,       0, 1,1,32'h0,0);
        add(0,0,4'h0,32'h0,   32'h0,       0, 0,0,32'h0,0);
        add(0,0,4'h0,32'h0,   32'h0,       0, 0,1,32'hDEADBEEF,0);
        add(1,1,4'h1,32'h40,  32'h000000AA,0, 1,0,32'h0,0);
        add(1,0,4'hF,32'h40,  32'h0,       0, 1,0,32'h0,0);
        add(0,0,4'h0,32'h0,   32'h0,       0, 0,1,32'h0,0);
        add(0,0,4'h0,32'h0,   32'h0,       0, 0,1,32'hDEADBEAA,0);
        add(1,1,4'hF,32'h0,   32'h12345678,0, 1,0,32'h0,0);
        add(1,0,4'hF,32'h1000,32'h0,       0, 1,0,32'h0,0);
        add(1,0,4'hF,32'h0,   32'h0,       0, 1,1,32'h0,0);
        add(0,0,4'h0,32'h0,   32'h0,       0, 0,1,32'h0,1);
        add(0,0,4'h0,32'h0,   32'h0,       0, 0,1,32'h12345678,0);
        add(1,0,4'hF,32'h40,  32'h0,       1, 0,0,32'h0,0);
        add(1,0,4'hF,32'h40,  32'h0,       1, 0,0,32'h0,0);
        add(1,0,4'hF,32'h40,  32'h0,       1, 0,0,32'h0,0);
        add(1,0,4'hF,32'h40,  32'h0,       0, 1,0,32'h0,0);
        add(0,0,4'h0,32'h0,   32'h0,       0, 0,0,32'h0,0);
        add(0,0,4'h0,32'h0,   32'h0,       0, 0,1,32'hDEADBEAA,0);
        add(1,1,4'h0,32'h40,  32'hFFFFFFFF,0, 1,0,32'h0,0);
        add(1,0,4'hF,32'h40,  32'h0,       0, 1,0,32'h0,0);
        add(0,0,4'h0,32'h0,   32'h0,       0, 0,1,32'h0,0);
        add(0,0,4'h0,32'h0,   32'h0,       0, 0,1,32'hDEADBEAA,0);
        add(1,0,4'hF,32'h0,   32'h0,       0, 1,0,32'h0,0);
        add(1,0,4'hF,32'h40,  32'h0,       0, 1,0,32'h0,0);
        add(1,0,4'hF,32'h0,   32'h0,       0, 1,1,32'h12345678,0);
        add(1,0,4'hF,32'h43,  32'h0,       0, 1,1,32'hDEADBEAA,0);
        add(1,0,4'hF,32'h0,   32'h0,       0, 1,1,32'h12345678,0);
        add(1,0,4'hF,32'h40,  32'h0,       0, 1,1,32'hDEADBEAA,0);
        add(0,0,4'h0,32'h0,   32'h0,       0, 0,1,32'h12345678,0);
        add(0,0,4'h0,32'h0,   32'h0,       0, 0,1,32'hDEADBEAA,0);
        add(0,0,4'h0,32'h0,   32'h0,       0, 0,0,32'h0,0);

        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_rvalid", 32'(rvalid_o), 32'h0);
        chk("reset_rdata",  rdata_o,       32'h0);
        chk("reset_err",    32'(err_o),    32'h0);
        rst_ni = 1'b1;

        // Give words 0..31 known contents for the random phase.
        for (int i = 0; i < 32; i++) cycle(1, 1, 4'hF, 32'(i * 4), $urandom, 0);
        repeat (3) cycle(0, 0, 4'h0, 32'h0, 32'h0, 0);

        foreach (tbl[i]) begin
            cycle(tbl[i].r, tbl[i].w, tbl[i].b, tbl[i].a, tbl[i].d, tbl[i].s);
            chk("tbl_gnt",    32'(s_gnt), 32'(tbl[i].eg));
            chk("tbl_rvalid", 32'(s_rv),  32'(tbl[i].ev));
            chk("tbl_rdata",  s_rdata,    tbl[i].ed);
            chk("tbl_err",    32'(s_err), 32'(tbl[i].ee));
        end

        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 9) < 7);
            w = 1'($urandom_range(0, 1));
            b = 4'($urandom_range(0, 15));
            s = ($urandom_range(0, 9) < 2);
            d = $urandom;
            if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0001_0000;
            else a = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
            cycle(r, w, b, a, d, s);
        end
        repeat (6) cycle(0, 0, 4'h0, 32'h0, 32'h0, 0);

        // Two reads in flight, then reset while a write is presented.
        cycle(1, 0, 4'hF, 32'h0,  32'h0, 0);
        cycle(1, 0, 4'hF, 32'h40, 32'h0, 0);
        rst_ni = 1'b0; req_i = 1'b1; we_i = 1'b1; be_i = 4'hF;
        addr_i = 32'h40; wdata_i = 32'hFFFFFFFF; stall_i = 1'b0;
        #1;
        chk("rst_gnt",    32'(gnt_o),    32'h1);
        chk("rst_rvalid", 32'(rvalid_o), 32'h0);
        chk("rst_rdata",  rdata_o,       32'h0);
        chk("rst_err",    32'(err_o),    32'h0);
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_rvalid_hold", 32'(rvalid_o), 32'h0);
        req_i = 1'b0; we_i = 1'b0;
        rst_ni = 1'b1;
        q.delete();
        cyc += 2;
        repeat (3) cycle(0, 0, 4'h0, 32'h0, 32'h0, 0);
        cycle(1, 0, 4'hF, 32'h40, 32'h0, 0);
        cycle(1, 0, 4'hF, 32'h40, 32'h0, 0);
        cycle(1, 0, 4'hF, 32'h40, 32'h0, 0);
        repeat (4) cycle(0, 0, 4'h0, 32'h0, 32'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
